// File: rtl/rbs_pkg.sv
// Shared types and helpers for the pipelined ripple-borrow subtractor.
// Optional build macro: RBS_OVF_EN (adds the sign bits used for signed overflow).
package rbs_pkg;

  localparam int unsigned RBS_DEFAULT_WIDTH = 32;

  // One borrow stage per bit, so latency equals the operand width.
  function automatic int unsigned rbs_latency(input int unsigned width);
    return width;
  endfunction

  // Per-stage control slice. The a/b remainders and the partial difference
  // depend on the module's WIDTH parameter, so they travel beside this
  // struct as vectors of that width.
  typedef struct packed {
    logic valid;
    logic borrow;
`ifdef RBS_OVF_EN
    logic sign_a;
    logic sign_b;
`endif
  } rbs_ctrl_t;

endpackage

// File: rtl/rbs_stage.sv
// One full-subtractor bit cell plus its stage register.
// Skew: the a/b remainders shift right by one each stage, so bit 0 is always
// the bit this stage consumes. Deskew: the partial difference shifts right
// with the new bit entering at the MSB, so after WIDTH stages every bit sits
// in its final position.
// Optional build macro: RBS_OVF_EN (sign bits ride along in the control slice).
module rbs_stage
  import rbs_pkg::*;
#(
  parameter int unsigned WIDTH = RBS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  rbs_ctrl_t        ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] d_i,
  output rbs_ctrl_t        ctrl_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] d_o
);

  rbs_ctrl_t        ctrl_d, ctrl_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] d_d, d_q;
  logic             d_bit;

  // Bit cell on the lowest remaining operand bits, then skew/deskew shifts.
  always_comb begin
    d_bit         = a_i[0] ^ b_i[0] ^ ctrl_i.borrow;
    ctrl_d        = ctrl_i;
    ctrl_d.borrow = (~a_i[0] & b_i[0]) | (~(a_i[0] ^ b_i[0]) & ctrl_i.borrow);
    a_d           = a_i >> 1;
    b_d           = b_i >> 1;
    d_d           = d_i >> 1;
    d_d[WIDTH-1]  = d_bit;
  end

  // Stage register; holds while the pipe is stalled.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
    end else if (en) begin
      ctrl_q <= ctrl_d;
      a_q    <= a_d;
      b_q    <= b_d;
      d_q    <= d_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign d_o    = d_q;

endmodule

// File: rtl/pipelined_ripple_borrow_subtractor.sv
// Bit-pipelined ripple-borrow subtractor with a valid/ready handshake.
// {bout, diff} = a - b - bin, delivered WIDTH cycles after acceptance.
// Optional build macro: RBS_OVF_EN (signed overflow flag on ovf; tied 0 otherwise).
module pipelined_ripple_borrow_subtractor
  import rbs_pkg::*;
#(
  parameter int unsigned WIDTH = RBS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned DEPTH = rbs_latency(WIDTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("pipelined_ripple_borrow_subtractor: WIDTH must be >= 1");
  end

  rbs_ctrl_t        ctrl_s [0:DEPTH];
  logic [WIDTH-1:0] a_s    [0:DEPTH];
  logic [WIDTH-1:0] b_s    [0:DEPTH];
  logic [WIDTH-1:0] d_s    [0:DEPTH];
  logic             stall;

  // Any valid result not taken downstream freezes the whole pipe.
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall;
  end

  // Stage-0 inputs: a bubble enters with valid=0 and don't-care data.
  always_comb begin
    ctrl_s[0]        = '0;
    ctrl_s[0].valid  = in_valid;
    ctrl_s[0].borrow = bin;
`ifdef RBS_OVF_EN
    ctrl_s[0].sign_a = a[WIDTH-1];
    ctrl_s[0].sign_b = b[WIDTH-1];
`endif
    a_s[0] = a;
    b_s[0] = b;
    d_s[0] = '0;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    rbs_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk   (clk),
      .arst_n(arst_n),
      .en    (~stall),
      .ctrl_i(ctrl_s[k]),
      .a_i   (a_s[k]),
      .b_i   (b_s[k]),
      .d_i   (d_s[k]),
      .ctrl_o(ctrl_s[k+1]),
      .a_o   (a_s[k+1]),
      .b_o   (b_s[k+1]),
      .d_o   (d_s[k+1])
    );
  end

  // Outputs come straight from the last stage register, so they hold on stall.
  always_comb begin
    out_valid = ctrl_s[DEPTH].valid;
    diff      = d_s[DEPTH];
    bout      = ctrl_s[DEPTH].borrow;
`ifdef RBS_OVF_EN
    ovf = (ctrl_s[DEPTH].sign_a != ctrl_s[DEPTH].sign_b) &
          (d_s[DEPTH][WIDTH-1] != ctrl_s[DEPTH].sign_a);
`else
    ovf = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pipelined_ripple_borrow_subtractor.sv
// Scoreboard bench for pipelined_ripple_borrow_subtractor at WIDTH=8.
// Honours RBS_OVF_EN in the reference model when the macro is defined.
module tb_pipelined_ripple_borrow_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         arst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  pipelined_ripple_borrow_subtractor #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t e;
    int   r;
    r      = int'(ma) - int'(mb) - int'(mbin);
    e.diff = W'(r);
    e.bout = (r < 0);
`ifdef RBS_OVF_EN
    e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Drive one operation; push its expectation on the cycle it is accepted.
  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin);
    int unsigned waited;
    a        = sa;
    b        = sb;
    bin      = sbin;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(model(sa, sb, sbin));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop and compare on every output transfer; watch stall stability.
  logic         held_stall;
  logic [W-1:0] held_diff;
  logic         held_bout;
  logic         held_ovf;
  initial held_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (arst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("bout", 32'(bout), 32'(e.bout));
        chk("ovf",  32'(ovf),  32'(e.ovf));
      end
    end
    if (arst_n && out_valid && !out_ready) begin
      chk("in_ready_stall", 32'(in_ready), 32'd0);
      if (held_stall) begin
        chk("diff_hold", 32'(diff), 32'(held_diff));
        chk("bout_hold", 32'(bout), 32'(held_bout));
        chk("ovf_hold",  32'(ovf),  32'(held_ovf));
      end
      held_stall = 1'b1;
      held_diff  = diff;
      held_bout  = bout;
      held_ovf   = ovf;
    end else begin
      held_stall = 1'b0;
    end
  end

  initial begin
    int unsigned waited;
    arst_n    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_diff",      32'(diff),      32'd0);
    chk("rst_bout",      32'(bout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    idle(2);
    arst_n = 1'b1;
    idle(2);

    // First operation: exact latency of W cycles
    send(8'h05, 8'h03, 1'b0);
    for (int unsigned i = 1; i < W; i++) begin
      @(negedge clk);
      chk("latency_early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("first_diff",    32'(diff),      32'h02);
    chk("first_bout",    32'(bout),      32'd0);
    @(posedge clk);
    #1;

    // Borrow ripple and boundaries, back to back
    send(8'h00, 8'h00, 1'b1);
    send(8'h10, 8'h20, 1'b0);
    send(8'h5A, 8'h5A, 1'b0);
    send(8'hFF, 8'h00, 1'b0);
    send(8'h00, 8'hFF, 1'b1);
    send(8'hFF, 8'hFF, 1'b1);

    // 20 random operations back to back
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
    end
    idle(W + 2);

    // Stall of 3 cycles while a result is presented
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
    end
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("stall_setup_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idle(3);
    out_ready = 1'b1;
    idle(W + 2);

    // Random valid gaps against random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(8'($urandom), 8'($urandom), 1'($urandom));
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    idle(W + 4);

    // Reset with operations in flight
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff",      32'(diff),      32'd0);
    chk("midrst_bout",      32'(bout),      32'd0);
    exp_q.delete();
    idle(2);
    arst_n = 1'b1;
    for (int unsigned i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Signed overflow corner cases
    send(8'h80, 8'h01, 1'b0);
    send(8'h7F, 8'h01, 1'b0);
    send(8'h7F, 8'hFF, 1'b0);

    // Drain
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      waited++;
      @(posedge clk);
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
